// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared fetch-stage types: sequencer state, next-PC select code and PC defaults.
package pc_fetch_sequencer_pkg;

  localparam int unsigned PC_WIDTH_DEF     = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    FETCH    = 2'd1,
    WAIT_MEM = 2'd2,
    HOLD     = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'd0,
    SEL_BR   = 2'd1,
    SEL_JMP  = 2'd2,
    SEL_HOLD = 2'd3
  } pc_sel_e;

  typedef struct packed {
    logic if_id;
    logic id_ex;
  } flush_t;

endpackage

// File: rtl/pc_incr.sv
// PC incrementor: modulo-2^WIDTH add of a fixed step, wraps silently.
module pc_incr #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned INCR  = 1
) (
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_inc
);

  assign pc_inc = pc + WIDTH'(INCR);

endmodule

// File: rtl/pc_next_select.sv
// Combinational next-PC priority: branch > jump > hold > sequential, plus flushes.
module pc_next_select
  import pc_fetch_sequencer_pkg::*;
(
  input  logic         active,
  input  fetch_state_e state,
  input  logic         stall_i,
  input  logic         imem_ready_i,
  input  logic         br_taken_i,
  input  logic         jmp_valid_i,
  output pc_sel_e      sel,
  output flush_t       flush
);

  always_comb begin
    sel   = SEL_HOLD;
    flush = '0;
    if (active) begin
      if (br_taken_i) begin
        // the jump, if any, is younger than the branch and is squashed with it
        sel   = SEL_BR;
        flush = '{if_id: 1'b1, id_ex: 1'b1};
      end else if (jmp_valid_i) begin
        sel         = SEL_JMP;
        flush.if_id = 1'b1;
      end else if (stall_i || (!imem_ready_i && state != HOLD)) begin
        sel = SEL_HOLD;
      end else begin
        sel = SEL_SEQ;
      end
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch PC owner for the 5-stage pipeline. Optional perf counters via PC_FETCH_PERF_EN.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int unsigned          PC_WIDTH     = PC_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEF),
  parameter int unsigned          INCR         = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_i,
  input  logic                imem_ready_i,
  input  logic                br_taken_i,
  input  logic [PC_WIDTH-1:0] br_target_i,
  input  logic                jmp_valid_i,
  input  logic [PC_WIDTH-1:0] jmp_target_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic                pc_valid_o,
  output logic [PC_WIDTH-1:0] next_pc_o,
  output logic                flush_if_id_o,
`ifdef PC_FETCH_PERF_EN
  output logic                flush_id_ex_o,
  output logic [31:0]         perf_redirects_o,
  output logic [31:0]         perf_stall_cycles_o,
  output logic [31:0]         perf_mem_wait_o
`else
  output logic                flush_id_ex_o
`endif
);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_seq;
  pc_sel_e             sel;
  flush_t              flush;
  logic                active, redirect;

  // reset and BOOT both mask redirects and flushes
  assign active = !reset && (state_q != BOOT);

  pc_incr #(.WIDTH(PC_WIDTH), .INCR(INCR)) u_incr (
    .pc     (pc_q),
    .pc_inc (pc_seq)
  );

  pc_next_select u_sel (
    .active       (active),
    .state        (state_q),
    .stall_i      (stall_i),
    .imem_ready_i (imem_ready_i),
    .br_taken_i   (br_taken_i),
    .jmp_valid_i  (jmp_valid_i),
    .sel          (sel),
    .flush        (flush)
  );

  assign redirect = (sel == SEL_BR) || (sel == SEL_JMP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (sel)
      SEL_BR:  pc_d = br_target_i;
      SEL_JMP: pc_d = jmp_target_i;
      SEL_SEQ: pc_d = pc_seq;
      default: pc_d = pc_q;
    endcase
    unique case (state_q)
      BOOT: state_d = FETCH;
      HOLD: begin
        if (redirect)     state_d = imem_ready_i ? FETCH : WAIT_MEM;
        else if (stall_i) state_d = HOLD;
        else              state_d = FETCH;
      end
      default: begin
        // FETCH and WAIT_MEM share transitions; memory readiness outranks the stall
        if (redirect)           state_d = imem_ready_i ? FETCH : WAIT_MEM;
        else if (!imem_ready_i) state_d = WAIT_MEM;
        else if (stall_i)       state_d = HOLD;
        else                    state_d = FETCH;
      end
    endcase
  end

  assign pc_o          = pc_q;
  assign next_pc_o     = pc_seq;
  assign pc_valid_o    = active;
  assign flush_if_id_o = flush.if_id;
  assign flush_id_ex_o = flush.id_ex;

`ifdef PC_FETCH_PERF_EN
  logic [31:0] redir_cnt, stall_cnt, wait_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      redir_cnt <= '0;
      stall_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (redirect && redir_cnt != '1)           redir_cnt <= redir_cnt + 32'd1;
      if (state_q == HOLD && stall_cnt != '1)    stall_cnt <= stall_cnt + 32'd1;
      if (state_q == WAIT_MEM && wait_cnt != '1) wait_cnt  <= wait_cnt + 32'd1;
    end
  end

  assign perf_redirects_o    = redir_cnt;
  assign perf_stall_cycles_o = stall_cnt;
  assign perf_mem_wait_o     = wait_cnt;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed scoreboard bench: driver queues per-cycle expectations, monitor checks them.
module tb_pc_fetch_sequencer;

  logic        clk, reset;
  logic        stall_i, imem_ready_i, br_taken_i, jmp_valid_i;
  logic [31:0] br_target_i, jmp_target_i;
  logic [31:0] pc_o, next_pc_o;
  logic        pc_valid_o, flush_if_id_o, flush_id_ex_o;
`ifdef PC_FETCH_PERF_EN
  logic [31:0] perf_redirects_o, perf_stall_cycles_o, perf_mem_wait_o;
`endif

  pc_fetch_sequencer dut (
    .clk                 (clk),
    .reset               (reset),
    .stall_i             (stall_i),
    .imem_ready_i        (imem_ready_i),
    .br_taken_i          (br_taken_i),
    .br_target_i         (br_target_i),
    .jmp_valid_i         (jmp_valid_i),
    .jmp_target_i        (jmp_target_i),
    .pc_o                (pc_o),
    .pc_valid_o          (pc_valid_o),
    .next_pc_o           (next_pc_o),
    .flush_if_id_o       (flush_if_id_o),
`ifdef PC_FETCH_PERF_EN
    .flush_id_ex_o       (flush_id_ex_o),
    .perf_redirects_o    (perf_redirects_o),
    .perf_stall_cycles_o (perf_stall_cycles_o),
    .perf_mem_wait_o     (perf_mem_wait_o)
`else
    .flush_id_ex_o       (flush_id_ex_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          step;
    logic [31:0] pc;
    logic        vld;
    logic        fif;
    logic        fex;
    logic        chk_perf;
    logic [31:0] p_redir;
    logic [31:0] p_stall;
    logic [31:0] p_wait;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL step %0d %s: got %h expected %h", step, name, act, expv);
    end
  endtask

  // monitor: one expectation per cycle, sampled on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pc_o",          e.step, pc_o,                  e.pc);
        chk("pc_valid_o",    e.step, {31'd0, pc_valid_o},    {31'd0, e.vld});
        chk("next_pc_o",     e.step, next_pc_o,             e.pc + 32'd1);
        chk("flush_if_id_o", e.step, {31'd0, flush_if_id_o}, {31'd0, e.fif});
        chk("flush_id_ex_o", e.step, {31'd0, flush_id_ex_o}, {31'd0, e.fex});
`ifdef PC_FETCH_PERF_EN
        if (e.chk_perf) begin
          chk("perf_redirects",    e.step, perf_redirects_o,    e.p_redir);
          chk("perf_stall_cycles", e.step, perf_stall_cycles_o, e.p_stall);
          chk("perf_mem_wait",     e.step, perf_mem_wait_o,     e.p_wait);
        end
`endif
      end
    end
  end

  // apply one cycle of inputs and queue the outputs expected during that cycle
  task automatic step(input logic rst, input logic stl, input logic rdy,
                      input logic br, input logic [31:0] brt,
                      input logic jmp, input logic [31:0] jmpt,
                      input logic [31:0] epc, input logic evld,
                      input logic efif, input logic efex);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; stall_i = stl; imem_ready_i = rdy;
    br_taken_i = br; br_target_i = brt; jmp_valid_i = jmp; jmp_target_i = jmpt;
    step_no++;
    e = '{step: step_no, pc: epc, vld: evld, fif: efif, fex: efex,
          chk_perf: 1'b0, p_redir: 32'd0, p_stall: 32'd0, p_wait: 32'd0};
    exp_q.push_back(e);
  endtask

  task automatic perf_expect(input logic [31:0] r, input logic [31:0] s, input logic [31:0] w);
    exp_q[exp_q.size()-1].chk_perf = 1'b1;
    exp_q[exp_q.size()-1].p_redir  = r;
    exp_q[exp_q.size()-1].p_stall  = s;
    exp_q[exp_q.size()-1].p_wait   = w;
  endtask

  initial begin
    reset = 1'b1; stall_i = 1'b0; imem_ready_i = 1'b1;
    br_taken_i = 1'b0; br_target_i = '0; jmp_valid_i = 1'b0; jmp_target_i = '0;
    //    rst  stl  rdy  br   brt          jmp  jmpt         pc           vld  fif  fex
    // reset 3 cycles; a branch during reset must not flush
    step(1, 0, 1, 1, 32'h55,       0, 0,            32'h0,       0, 0, 0);
    step(1, 0, 1, 0, 0,            0, 0,            32'h0,       0, 0, 0);
    step(1, 0, 1, 0, 0,            0, 0,            32'h0,       0, 0, 0);
    // BOOT bubble; redirect in BOOT ignored
    step(0, 0, 1, 1, 32'h77,       0, 0,            32'h0,       0, 0, 0);
    step(0, 0, 1, 0, 0,            0, 0,            32'h0,       1, 0, 0);
    step(0, 0, 1, 0, 0,            0, 0,            32'h1,       1, 0, 0);
    step(0, 0, 1, 0, 0,            0, 0,            32'h2,       1, 0, 0);
    step(0, 0, 1, 0, 0,            0, 0,            32'h3,       1, 0, 0);
    step(0, 0, 1, 0, 0,            0, 0,            32'h4,       1, 0, 0);
    // stall two cycles at pc 5
    step(0, 1, 1, 0, 0,            0, 0,            32'h5,       1, 0, 0);
    step(0, 1, 1, 0, 0,            0, 0,            32'h5,       1, 0, 0);
    step(0, 0, 1, 0, 0,            0, 0,            32'h5,       1, 0, 0);
    step(0, 0, 1, 0, 0,            0, 0,            32'h6,       1, 0, 0);
    step(0, 0, 1, 0, 0,            0, 0,            32'h7,       1, 0, 0);
    // branch beats stall and same-cycle jump
    step(0, 1, 1, 1, 32'h40,       1, 32'h80,       32'h8,       1, 1, 1);
    step(0, 0, 1, 0, 0,            0, 0,            32'h40,      1, 0, 0);
    step(0, 0, 1, 1, 32'h3,        0, 0,            32'h41,      1, 1, 1);
    // memory not ready for 4 cycles, jump during the wait
    step(0, 0, 0, 0, 0,            0, 0,            32'h3,       1, 0, 0);
    step(0, 0, 0, 0, 0,            1, 32'h20,       32'h3,       1, 1, 0);
    step(0, 0, 0, 0, 0,            0, 0,            32'h20,      1, 0, 0);
    step(0, 0, 0, 0, 0,            0, 0,            32'h20,      1, 0, 0);
    step(0, 0, 1, 0, 0,            0, 0,            32'h20,      1, 0, 0);
    // wrap at the top of the address space
    step(0, 0, 1, 1, 32'hFFFF_FFFE, 0, 0,           32'h21,      1, 1, 1);
    step(0, 0, 1, 0, 0,            0, 0,            32'hFFFF_FFFE, 1, 0, 0);
    step(0, 0, 1, 0, 0,            0, 0,            32'hFFFF_FFFF, 1, 0, 0);
    // jump out of HOLD while still stalled
    step(0, 1, 1, 0, 0,            0, 0,            32'h0,       1, 0, 0);
    step(0, 1, 1, 0, 0,            1, 32'h30,       32'h0,       1, 1, 0);
    step(0, 0, 1, 0, 0,            0, 0,            32'h30,      1, 0, 0);
    step(0, 0, 1, 0, 0,            0, 0,            32'h31,      1, 0, 0);
    // reset during a redirect discards it
    step(1, 0, 1, 1, 32'h99,       0, 0,            32'h32,      0, 0, 0);
    perf_expect(32'd5, 32'd3, 32'd4);
    step(0, 0, 1, 0, 0,            0, 0,            32'h0,       0, 0, 0);
    perf_expect(32'd0, 32'd0, 32'd0);
    step(0, 0, 1, 0, 0,            0, 0,            32'h0,       1, 0, 0);
    step(0, 0, 1, 0, 0,            0, 0,            32'h1,       1, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
